load_store_unit: RTL and testbench

//  Parametrised data-memory access unit for the multicycle core; replaces the fixed 2-cycle load timer.

---
 rtl/core_pkg.sv | 17 +
 rtl/lsu_lat_cnt.sv | 56 +++++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the core's load/store path.
// Provides the LSU state encoding, the hard-wired zero register index and
// the default datapath widths used by the load/store unit.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STORE     = 2'd1,
    LOAD_WAIT = 2'd2,
    WB        = 2'd3
  } lsu_state_t;

  localparam int unsigned REG_ZERO   = 0;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_AW_DEF = 5;

endpackage

// File: rtl/lsu_lat_cnt.sv
// BRAM read-latency counter for the load/store unit.
// Ports:
//   clk_i    core clock
//   rst_i    asynchronous reset, active-high
//   start_i  load accepted this cycle; restart the count
//   clear_i  abandon/finish the count
//   done_o   read data is valid on the BRAM output this cycle
// The first cycle after start is the address cycle (the BRAM samples the
// registered address at its end); cnt then runs 0..RD_LAT-1 and done_o is
// raised at RD_LAT-1, i.e. RD_LAT+1 cycles after the start edge.
module lsu_lat_cnt #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic clear_i,
  output logic done_o
);

  localparam int unsigned CntW = $clog2(RD_LAT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(RD_LAT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            addr_phase_q, addr_phase_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      addr_phase_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      addr_phase_q <= addr_phase_d;
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    addr_phase_d = addr_phase_q;
    if (clear_i) begin
      cnt_d        = '0;
      addr_phase_d = 1'b0;
    end else if (start_i) begin
      cnt_d        = '0;
      addr_phase_d = 1'b1;
    end else if (addr_phase_q) begin
      addr_phase_d = 1'b0;
    end else if (cnt_q != LastCnt) begin
      // saturate so an idle counter never wraps
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign done_o = !addr_phase_q && (cnt_q == LastCnt);

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access unit for the multicycle core.
// Accepts one load or store per valid/ready handshake, drives the data BRAM
// port, waits RD_LAT cycles for read data and returns loads as a one-cycle
// writeback pulse. Out-of-range addresses raise addr_err_o without touching
// memory.
// Ports:
//   clk_i, rst_i            core clock, asynchronous active-high reset
//   req_valid_i/req_ready_o request handshake (ready = unit idle)
//   req_we_i                1 = store, 0 = load
//   req_addr_i/req_wdata_i  word address / store data
//   req_rd_i                load destination register
//   mem_addr_o/mem_we_o/mem_wdata_o/mem_rdata_i  BRAM port
//   wb_valid_o/wb_addr_o/wb_data_o               load writeback
//   st_done_o               one-cycle store-complete strobe
//   addr_err_o              one-cycle out-of-range strobe
module load_store_unit
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned MEM_AW = 17,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [REG_AW-1:0] req_rd_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              wb_valid_o,
  output logic [REG_AW-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              st_done_o,
  output logic              addr_err_o
);

  // Address bits above the implemented BRAM; any of them set is out of range.
  localparam logic [ADDR_W-1:0] HiMask =
      (MEM_AW >= ADDR_W) ? '0 : ~((ADDR_W'(1) << MEM_AW) - ADDR_W'(1));

  lsu_state_t state_q, state_d;

  logic              ready_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              addr_err_q;
  logic              lat_done;

  logic accept;
  logic out_of_range;
  logic go;

  assign accept       = req_valid_i & ready_q;
  assign out_of_range = |(req_addr_i & HiMask);
  assign go           = accept & ~out_of_range;

  lsu_lat_cnt #(
    .RD_LAT (RD_LAT)
  ) u_lat_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (go & ~req_we_i),
    .clear_i (state_q == WB),
    .done_o  (lat_done)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = req_we_i ? STORE : LOAD_WAIT;
        end
      end
      STORE:     state_d = IDLE;
      LOAD_WAIT: begin
        if (lat_done) begin
          state_d = WB;
        end
      end
      WB:        state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Request and writeback registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q     <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_q        <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      ready_q    <= (state_d == IDLE);
      addr_err_q <= accept & out_of_range;
      if (go) begin
        mem_addr_q <= req_addr_i;
        if (req_we_i) begin
          mem_wdata_q <= req_wdata_i;
        end else begin
          rd_q <= req_rd_i;
        end
      end
      if ((state_q == LOAD_WAIT) && lat_done) begin
        wb_addr_q <= rd_q;
        wb_data_q <= mem_rdata_i;
      end
    end
  end

  // Outputs: strobes decode the state register so reset removes them at once
  always_comb begin
    req_ready_o = ready_q;
    mem_addr_o  = mem_addr_q;
    mem_wdata_o = mem_wdata_q;
    mem_we_o    = (state_q == STORE);
    st_done_o   = (state_q == STORE);
    wb_addr_o   = wb_addr_q;
    wb_data_o   = wb_data_q;
    wb_valid_o  = (state_q == WB) && (wb_addr_q != REG_AW'(REG_ZERO));
    addr_err_o  = addr_err_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: three instances with RD_LAT 2, 1
// and 7, each with a behavioural BRAM model. Expected stores and writebacks
// are queued at the accept edge and compared when the DUT strobes.
module tb_load_store_unit;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0]       req_valid, req_we, req_ready, mem_we, wb_valid, st_done, addr_err;
  logic [NI-1:0][31:0] req_addr, req_wdata, mem_addr, mem_wdata, mem_rdata, wb_data;
  logic [NI-1:0][4:0]  req_rd, wb_addr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          g;
    logic [31:0] a;
    logic [31:0] d;
    int          t;
  } exp_t;

  exp_t        wbq[$];
  exp_t        stq[$];
  logic [31:0] shadow [NI][256];

  function automatic int lat_of(int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 7);
  endfunction

  function automatic logic [31:0] pat(int i);
    return 32'hC0DE0000 ^ (32'(i) * 32'h01010101);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
    logic [31:0] mem  [256];
    logic [31:0] pipe [Lat];

    initial for (int i = 0; i < 256; i++) mem[i] = pat(i);

    always @(posedge clk) begin
      if (mem_we[g]) mem[mem_addr[g][7:0]] <= mem_wdata[g];
      pipe[0] <= mem[mem_addr[g][7:0]];
      for (int i = 1; i < Lat; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = pipe[Lat-1];

    load_store_unit #(
      .DATA_W (32),
      .ADDR_W (32),
      .MEM_AW (17),
      .RD_LAT (Lat),
      .REG_AW (5)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_we_i    (req_we[g]),
      .req_addr_i  (req_addr[g]),
      .req_wdata_i (req_wdata[g]),
      .req_rd_i    (req_rd[g]),
      .mem_addr_o  (mem_addr[g]),
      .mem_we_o    (mem_we[g]),
      .mem_wdata_o (mem_wdata[g]),
      .mem_rdata_i (mem_rdata[g]),
      .wb_valid_o  (wb_valid[g]),
      .wb_addr_o   (wb_addr[g]),
      .wb_data_o   (wb_data[g]),
      .st_done_o   (st_done[g]),
      .addr_err_o  (addr_err[g])
    );
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (wb_valid[g] !== 1'b0) begin
        int k;
        k = -1;
        for (int i = 0; i < wbq.size(); i++) if (k < 0 && wbq[i].g == g) k = i;
        if (k < 0) begin
          chk("wb_spurious", 64'(wb_valid[g]), 0);
        end else begin
          chk("wb_addr", 64'(wb_addr[g]), 64'(wbq[k].a));
          chk("wb_data", 64'(wb_data[g]), 64'(wbq[k].d));
          chk("wb_cycle", 64'(cyc), 64'(wbq[k].t));
          wbq.delete(k);
        end
      end
      if (mem_we[g] !== 1'b0 || st_done[g] !== 1'b0) begin
        int k;
        k = -1;
        for (int i = 0; i < stq.size(); i++) if (k < 0 && stq[i].g == g) k = i;
        if (k < 0) begin
          chk("st_spurious_we", 64'(mem_we[g]), 0);
          chk("st_spurious_done", 64'(st_done[g]), 0);
        end else begin
          chk("st_mem_we", 64'(mem_we[g]), 1);
          chk("st_done", 64'(st_done[g]), 1);
          chk("st_addr", 64'(mem_addr[g]), 64'(stq[k].a));
          chk("st_wdata", 64'(mem_wdata[g]), 64'(stq[k].d));
          chk("st_cycle", 64'(cyc), 64'(stq[k].t));
          stq.delete(k);
        end
      end
    end
  end

  // Drive a request, hold it until accepted, queue its expected result and
  // return at the negedge right after the accept edge (valid still high).
  task automatic do_req(int g, bit we, logic [31:0] a, logic [31:0] d, logic [4:0] rd);
    int   n = 0;
    exp_t e;
    bit   oor;
    req_we[g]    = we;
    req_addr[g]  = a;
    req_wdata[g] = d;
    req_rd[g]    = rd;
    req_valid[g] = 1'b1;
    while (req_ready[g] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (req_ready[g] !== 1'b1) chk("accept_timeout", 64'(req_ready[g]), 1);
    @(posedge clk);
    #1;
    oor = |a[31:17];
    e.g = g;
    if (oor) begin
      e.t = 0;
    end else if (we) begin
      e.a = a;
      e.d = d;
      e.t = cyc;
      stq.push_back(e);
      shadow[g][a[7:0]] = d;
    end else if (rd != 5'd0) begin
      e.a = 32'(rd);
      e.d = shadow[g][a[7:0]];
      e.t = cyc + lat_of(g) + 1;
      wbq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(int g);
    req_valid[g] = 1'b0;
  endtask

  // Count busy cycles from the negedge after accept until ready returns.
  task automatic ready_low(int g, int exp_n);
    int n = 0;
    while (req_ready[g] === 1'b0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("ready_low_cycles", 64'(n), 64'(exp_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] saved;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_rd    = '0;
    for (int g = 0; g < NI; g++) for (int i = 0; i < 256; i++) shadow[g][i] = pat(i);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(3'b111));
    chk("rst_mem_we", 64'(mem_we), 0);
    chk("rst_wb_valid", 64'(wb_valid), 0);
    chk("rst_st_done", 64'(st_done), 0);
    chk("rst_addr_err", 64'(addr_err), 0);
    chk("rst_mem_addr", 64'(mem_addr[0]), 0);
    chk("rst_wb_data", 64'(wb_data[0]), 0);
    rst = 1'b0;
    @(negedge clk);

    // Store: one cycle after accept, ready back the cycle after
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0);
    chk("t1_mem_we", 64'(mem_we[0]), 1);
    chk("t1_mem_addr", 64'(mem_addr[0]), 64'h10);
    chk("t1_mem_wdata", 64'(mem_wdata[0]), 64'hDEADBEEF);
    chk("t1_st_done", 64'(st_done[0]), 1);
    chk("t1_ready_busy", 64'(req_ready[0]), 0);
    idle(0);
    @(negedge clk);
    chk("t1_ready_back", 64'(req_ready[0]), 1);
    chk("t1_we_off", 64'(mem_we[0]), 0);

    // Loads on each latency; busy spans RD_LAT+1 wait cycles plus the WB cycle
    do_req(0, 1'b0, 32'h10, 32'h0, 5'd5);
    idle(0);
    ready_low(0, lat_of(0) + 2);
    chk("t2_wb_addr_hold", 64'(wb_addr[0]), 5);
    chk("t2_wb_data_hold", 64'(wb_data[0]), 64'hDEADBEEF);
    chk("t2_wb_valid_off", 64'(wb_valid[0]), 0);
    for (int g = 1; g < NI; g++) begin
      do_req(g, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0);
      idle(g);
      @(negedge clk);
      do_req(g, 1'b0, 32'h10, 32'h0, 5'd5);
      idle(g);
      ready_low(g, lat_of(g) + 2);
    end

    // Load to register 0: full timing, no writeback
    do_req(0, 1'b0, 32'h20, 32'h0, 5'd0);
    idle(0);
    ready_low(0, lat_of(0) + 2);

    // Out of range: error strobe only, unit stays ready
    do_req(0, 1'b0, 32'h20000, 32'h0, 5'd3);
    chk("t4_addr_err", 64'(addr_err[0]), 1);
    chk("t4_mem_we", 64'(mem_we[0]), 0);
    chk("t4_ready", 64'(req_ready[0]), 1);
    idle(0);
    @(negedge clk);
    chk("t4_addr_err_off", 64'(addr_err[0]), 0);
    do_req(0, 1'b1, 32'h80000000, 32'h12345678, 5'd0);
    chk("t4_store_err", 64'(addr_err[0]), 1);
    chk("t4_store_no_we", 64'(mem_we[0]), 0);
    idle(0);
    @(negedge clk);
    // Highest in-range address
    do_req(0, 1'b0, 32'h1FFFF, 32'h0, 5'd9);
    idle(0);
    ready_low(0, lat_of(0) + 2);

    // Back-to-back with valid held throughout
    do_req(0, 1'b1, 32'h40, 32'h11112222, 5'd0);
    do_req(0, 1'b0, 32'h40, 32'h0, 5'd7);
    do_req(0, 1'b1, 32'h41, 32'h33334444, 5'd0);
    idle(0);
    repeat (8) @(negedge clk);

    // Reset one cycle into the load wait
    do_req(0, 1'b0, 32'h41, 32'h0, 5'd9);
    idle(0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    wbq.pop_back();
    chk("t6_mem_we", 64'(mem_we[0]), 0);
    chk("t6_wb_valid", 64'(wb_valid[0]), 0);
    chk("t6_ready", 64'(req_ready[0]), 1);
    chk("t6_mem_addr", 64'(mem_addr[0]), 0);
    chk("t6_wb_addr", 64'(wb_addr[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    do_req(0, 1'b0, 32'h41, 32'h0, 5'd9);
    idle(0);
    ready_low(0, lat_of(0) + 2);

    // Reset during a store cuts mem_we at once; the write never happens
    saved = shadow[0][8'h42];
    do_req(0, 1'b1, 32'h42, 32'h5555AAAA, 5'd0);
    idle(0);
    #1 rst = 1'b1;
    #1;
    shadow[0][8'h42] = saved;
    chk("t6_store_cut", 64'(mem_we[0]), 0);
    chk("t6_store_done_cut", 64'(st_done[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_req(0, 1'b0, 32'h42, 32'h0, 5'd4);
    idle(0);
    ready_low(0, lat_of(0) + 2);

    repeat (15) @(negedge clk);
    chk("wbq_drained", 64'(wbq.size()), 0);
    chk("stq_drained", 64'(stq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
